// File: rtl/mem_port_sched_if.sv
// Core-side request/response signals and main-memory port of mem_port_sched.
//
// Handshake semantics:
//   Core side: a requester raises *_req and holds every *_addr/ls_* field stable
//   until its *_rvalid pulse. *_rvalid is high for exactly one cycle, and
//   *_rdata/*_err are valid only in that cycle. A req still high in the cycle
//   after rvalid counts as a new request.
//   Memory side: mem_req and all mem_* fields stay stable until a cycle with
//   mem_ready = 1, which completes the access. For reads, mem_rdata is valid
//   in that same cycle. mem_req may also drop without mem_ready on a timeout
//   abort or on reset.
interface mem_port_sched_if #(
   parameter int MEM_AW = 24
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_err;

   logic              ls_req;
   logic              ls_we;
   logic [2:0]        ls_func3;
   logic [31:0]       ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_rvalid;
   logic [31:0]       ls_rdata;
   logic              ls_err;

   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   // Scheduler view.
   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_func3, ls_addr, ls_wdata,
             mem_ready, mem_rdata,
      output if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, ls_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   // Environment view: the core requesters plus the memory.
   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_func3, ls_addr, ls_wdata,
             mem_ready, mem_rdata,
      input  if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, ls_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_port_sched.sv
// Main-memory port scheduler. Arbitrates instruction fetch and load/store
// traffic onto a single memory port and translates byte addresses to
// memory-relative word addresses. It builds byte enables, replicates store
// data across lanes, and aligns and extends load data. Each access runs under
// a timeout; range, alignment and size faults are answered without a memory
// cycle.
module mem_port_sched #(
   parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
   parameter int          MEM_AW     = 24,
   parameter int          TIMEOUT    = 16,
   parameter int          MAX_LS_RUN = 4
) (
   input  logic            clock,
   input  logic            reset,
   mem_port_sched_if.slave bus,
   output logic            busy,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int RUN_W = $clog2(MAX_LS_RUN + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_LS_RUN);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [32:0]      MEM_BYTES = 33'd1 << (MEM_AW + 2);

   state_t            state_q, state_d;
   logic [RUN_W-1:0]  ls_run_q, ls_run_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              sel_ls_q, sel_ls_d;
   logic [1:0]        lane_q, lane_d;
   logic [2:0]        func3_q, func3_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              ls_rvalid_q, ls_rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   // Request decode for whichever port wins arbitration this cycle.
   logic        grant_ls, grant_if;
   logic [31:0] req_addr, req_off, req_wdata;
   logic [2:0]  req_func3;
   logic        req_we, range_bad, func_bad, align_bad, req_fault;
   logic [3:0]  req_be;

   // Shift the addressed lane down and extend it by access size and signedness.
   function automatic logic [31:0] align_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3[1:0])
         2'b00:   align_load = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
         2'b01:   align_load = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
         default: align_load = sh;
      endcase
   endfunction

   // Arbitration and fault/enable/data decode of the candidate request.
   always_comb begin
      grant_ls  = bus.ls_req && (!bus.if_req || (ls_run_q != RUN_MAX));
      grant_if  = bus.if_req && !grant_ls;
      req_addr  = grant_ls ? bus.ls_addr : bus.if_addr;
      req_func3 = grant_ls ? bus.ls_func3 : 3'b010;
      req_we    = grant_ls && bus.ls_we;
      req_off   = req_addr - BASE_ADDR;
      range_bad = (req_addr < BASE_ADDR) || ({1'b0, req_off} >= MEM_BYTES);
      func_bad  = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11);
      case (req_func3[1:0])
         2'b00: begin
            align_bad = 1'b0;
            req_be    = 4'b0001 << req_addr[1:0];
            req_wdata = {4{bus.ls_wdata[7:0]}};
         end
         2'b01: begin
            align_bad = req_addr[0];
            req_be    = 4'b0011 << req_addr[1:0];
            req_wdata = {2{bus.ls_wdata[15:0]}};
         end
         default: begin
            align_bad = |req_addr[1:0];
            req_be    = 4'b1111;
            req_wdata = bus.ls_wdata;
         end
      endcase
      if (!req_we) req_wdata = '0;
      req_fault = range_bad | func_bad | align_bad;
   end

   // Next-state logic: IDLE arbitrates, MEM waits for ready or timeout, RESP pulses rvalid.
   always_comb begin
      state_d     = state_q;
      ls_run_d    = ls_run_q;
      tmo_d       = tmo_q;
      sel_ls_d    = sel_ls_q;
      lane_d      = lane_q;
      func3_d     = func3_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;

      // The LS run only counts while fetch is actually being held off.
      if (!bus.if_req) ls_run_d = '0;

      case (state_q)
         S_IDLE: begin
            rdata_d = '0;
            err_d   = 1'b0;
            if (grant_ls || grant_if) begin
               sel_ls_d = grant_ls;
               lane_d   = req_addr[1:0];
               func3_d  = req_func3;
               if (grant_if) begin
                  ls_run_d = '0;
               end else if (bus.if_req) begin
                  ls_run_d = ls_run_q + RUN_W'(1);
               end
               if (req_fault) begin
                  state_d     = S_RESP;
                  err_d       = 1'b1;
                  if_rvalid_d = grant_if;
                  ls_rvalid_d = grant_ls;
               end else begin
                  state_d     = S_MEM;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = req_off[MEM_AW+1:2];
                  mem_be_d    = req_be;
                  mem_wdata_d = req_wdata;
                  tmo_d       = '0;
               end
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               state_d     = S_RESP;
               mem_req_d   = 1'b0;
               if_rvalid_d = !sel_ls_q;
               ls_rvalid_d = sel_ls_q;
               err_d       = 1'b0;
               if (!sel_ls_q)     rdata_d = bus.mem_rdata;
               else if (mem_we_q) rdata_d = '0;
               else               rdata_d = align_load(bus.mem_rdata, lane_q, func3_q);
            end else if (tmo_q == TMO_LAST) begin
               state_d     = S_RESP;
               mem_req_d   = 1'b0;
               if_rvalid_d = !sel_ls_q;
               ls_rvalid_d = sel_ls_q;
               err_d       = 1'b1;
               rdata_d     = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset drops mem_req and discards any access at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ls_run_q    <= '0;
         tmo_q       <= '0;
         sel_ls_q    <= 1'b0;
         lane_q      <= '0;
         func3_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ls_run_q    <= ls_run_d;
         tmo_q       <= tmo_d;
         sel_ls_q    <= sel_ls_d;
         lane_q      <= lane_d;
         func3_q     <= func3_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   // rdata/err registers are zero outside RESP; steer them to the owning port only.
   assign bus.if_rdata  = sel_ls_q ? 32'd0 : rdata_q;
   assign bus.if_err    = err_q & ~sel_ls_q;
   assign bus.ls_rdata  = sel_ls_q ? rdata_q : 32'd0;
   assign bus.ls_err    = err_q & sel_ls_q;
   assign busy          = (state_q != S_IDLE);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Self-checking bench for mem_port_sched: directed scenarios plus randomized
// IF/LS traffic compared against a byte-level reference model.
module tb_mem_port_sched;
   localparam logic [31:0] BASE       = 32'h0100_0000;
   localparam int          MEM_AW     = 24;
   localparam int          TIMEOUT    = 16;
   localparam int          MAX_LS_RUN = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       busy;
   logic [1:0] dbg_state;

   mem_port_sched_if #(.MEM_AW(MEM_AW)) bus();

   mem_port_sched #(
      .BASE_ADDR (BASE),
      .MEM_AW    (MEM_AW),
      .TIMEOUT   (TIMEOUT),
      .MAX_LS_RUN(MAX_LS_RUN)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .busy     (busy),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   int total = 0;
   int bad   = 0;

   // Memory responder: ready after mem_lat waiting cycles (-1 = never), captures the request.
   int                mem_lat  = 0;
   logic [31:0]       mem_word = 32'h0;
   int                wait_cnt = 0;
   int                req_hi_cnt = 0;
   int                rv_cnt = 0;
   int                overlap_cnt = 0;
   logic              cap_we;
   logic [MEM_AW-1:0] cap_addr;
   logic [3:0]        cap_be;
   logic [31:0]       cap_wdata;

   always @(negedge clock) begin
      bus.mem_rdata = mem_word;
      if (bus.mem_req === 1'b1) begin
         req_hi_cnt++;
         if (mem_lat >= 0 && wait_cnt == mem_lat) begin
            bus.mem_ready = 1'b1;
            cap_we    = bus.mem_we;
            cap_addr  = bus.mem_addr;
            cap_be    = bus.mem_be;
            cap_wdata = bus.mem_wdata;
         end else begin
            bus.mem_ready = 1'b0;
         end
         wait_cnt++;
      end else begin
         bus.mem_ready = 1'b0;
         wait_cnt = 0;
      end
      if (bus.if_rvalid === 1'b1 || bus.ls_rvalid === 1'b1) rv_cnt++;
      if (bus.if_rvalid === 1'b1 && bus.ls_rvalid === 1'b1) overlap_cnt++;
   end

   // Reference model: what a single access should produce, from byte-level rules.
   function automatic void ref_access(input logic is_ls, input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [31:0] word, output logic err,
                                      output logic [MEM_AW-1:0] maddr, output logic [3:0] be,
                                      output logic [31:0] wdata, output logic [31:0] rdata);
      logic [2:0]  fc;
      int unsigned nbytes;
      longint      off;
      logic [31:0] mask;
      fc     = is_ls ? f3 : 3'b010;
      nbytes = 1 << fc[1:0];
      off    = longint'(addr) - longint'(BASE);
      err    = (off < 0) || (off >= longint'(4) * (longint'(1) << MEM_AW)) ||
               (fc == 3'b011) || (fc >= 3'b110) || ((addr % nbytes) != 0);
      maddr  = MEM_AW'(off / 4);
      be     = 4'(((1 << nbytes) - 1) << (addr % 4));
      wdata  = '0;
      if (is_ls && we)
         for (int i = 0; i < 4; i++) wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      if (nbytes < 4) mask = (32'd1 << (8 * nbytes)) - 32'd1;
      else            mask = 32'hFFFF_FFFF;
      rdata = (word >> (8 * (addr % 4))) & mask;
      if (is_ls && !fc[2] && nbytes < 4 && rdata[8*nbytes-1]) rdata = rdata | ~mask;
      if ((is_ls && we) || err) rdata = '0;
   endfunction

   // Driver: one load/store transaction; lat = cycles from sampled req to ls_rvalid, 0 if no response within 100 cycles.
   task automatic ls_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int reqs);
      int r0;
      @(negedge clock);
      r0 = req_hi_cnt;
      bus.ls_we = we; bus.ls_func3 = f3; bus.ls_addr = addr; bus.ls_wdata = wd;
      bus.ls_req = 1'b1;
      lat = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (bus.ls_rvalid === 1'b1) begin
            lat = k; rd = bus.ls_rdata; er = bus.ls_err;
            break;
         end
      end
      bus.ls_req = 1'b0;
      reqs = req_hi_cnt - r0;
   endtask

   // Driver: one instruction fetch.
   task automatic if_txn(input logic [31:0] addr, output logic [31:0] rd, output logic er,
                         output int lat, output int reqs);
      int r0;
      @(negedge clock);
      r0 = req_hi_cnt;
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
      lat = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (bus.if_rvalid === 1'b1) begin
            lat = k; rd = bus.if_rdata; er = bus.if_err;
            break;
         end
      end
      bus.if_req = 1'b0;
      reqs = req_hi_cnt - r0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      total++; if ({bus.mem_req, bus.mem_we, bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err} !== 6'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=000000", {bus.mem_req, bus.mem_we, bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err}); end
      total++; if ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.if_rdata, bus.ls_rdata} !== '0) begin
         bad++; $display("FAIL reset_data got nonzero addr=%h be=%b wdata=%h", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_fetch();
      logic [31:0] rd; logic er; int lat, reqs;
      mem_lat = 0; mem_word = 32'h00A0_0093;
      if_txn(32'h0100_0010, rd, er, lat, reqs);
      total++; if (lat != 2) begin bad++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
      total++; if (rd !== 32'h00A0_0093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00a00093", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL fetch_err got=%b exp=0", er); end
      total++; if (cap_addr !== 24'h000004) begin bad++; $display("FAIL fetch_mem_addr got=%h exp=000004", cap_addr); end
      total++; if (cap_be !== 4'b1111) begin bad++; $display("FAIL fetch_be got=%b exp=1111", cap_be); end
      total++; if (reqs != 1) begin bad++; $display("FAIL fetch_req_cycles got=%0d exp=1", reqs); end
   endtask

   task automatic test_extension();
      logic [31:0] rd, a, e_wd, e_rd; logic er, e_err; int lat, reqs;
      logic [MEM_AW-1:0] e_ma; logic [3:0] e_be;
      logic [2:0] f3s [3];
      f3s[0] = 3'b000; f3s[1] = 3'b100; f3s[2] = 3'b001;
      a = BASE + 32'h20;
      mem_lat = 1; mem_word = 32'h80F0_7FFF;
      for (int i = 0; i < 3; i++) begin
         ref_access(1'b1, 1'b0, f3s[i], a + 32'd2, 32'h0, mem_word, e_err, e_ma, e_be, e_wd, e_rd);
         ls_txn(1'b0, f3s[i], a + 32'd2, 32'h0, rd, er, lat, reqs);
         total++; if (rd !== e_rd || er !== 1'b0) begin bad++; $display("FAIL ext_load f3=%b got=%h/%b exp=%h/0", f3s[i], rd, er, e_rd); end
         total++; if (cap_be !== e_be) begin bad++; $display("FAIL ext_be f3=%b got=%b exp=%b", f3s[i], cap_be, e_be); end
      end
      ls_txn(1'b1, 3'b000, a + 32'd3, 32'h1234_5678, rd, er, lat, reqs);
      total++; if (cap_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", cap_be); end
      total++; if (cap_wdata !== 32'h7878_7878) begin bad++; $display("FAIL sb_wdata got=%h exp=78787878", cap_wdata); end
      total++; if (cap_we !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL sb_we_rdata got=%b/%h exp=1/0", cap_we, rd); end
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic er; int lat, reqs;
      mem_lat = 0;
      ls_txn(1'b0, 3'b010, 32'h0100_0002, 32'h0, rd, er, lat, reqs);
      total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL lw_misalign got err=%b lat=%0d exp err=1 lat=1", er, lat); end
      total++; if (reqs != 0) begin bad++; $display("FAIL lw_misalign_memreq got=%0d exp=0", reqs); end
      if_txn(32'h0000_0100, rd, er, lat, reqs);
      total++; if (er !== 1'b1 || lat != 1 || rd !== 32'h0) begin bad++; $display("FAIL if_range got err=%b lat=%0d rd=%h exp 1/1/0", er, lat, rd); end
      total++; if (reqs != 0) begin bad++; $display("FAIL if_range_memreq got=%0d exp=0", reqs); end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; logic er; int lat, reqs;
      mem_lat = -1; mem_word = 32'hDEAD_BEEF;
      ls_txn(1'b0, 3'b010, BASE + 32'h40, 32'h0, rd, er, lat, reqs);
      total++; if (reqs != TIMEOUT) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", reqs, TIMEOUT); end
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL timeout_resp got err=%b rd=%h exp 1/0", er, rd); end
      total++; if (lat != TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TIMEOUT + 1); end
      mem_lat = 0;
   endtask

   task automatic test_back_to_back();
      logic [0:0] exp_q[$];
      logic [0:0] got_q[$];
      int run;
      run = 0;
      for (int g = 0; g < 10; g++) begin
         if (run == MAX_LS_RUN) begin exp_q.push_back(1'b1); run = 0; end
         else begin exp_q.push_back(1'b0); run++; end
      end
      @(negedge clock);
      mem_lat = 0; mem_word = 32'h1111_2222;
      bus.ls_we = 1'b0; bus.ls_func3 = 3'b010; bus.ls_addr = BASE + 32'h100; bus.ls_wdata = 32'h0;
      bus.if_addr = BASE + 32'h200;
      bus.ls_req = 1'b1; bus.if_req = 1'b1;
      for (int k = 0; k < 300 && got_q.size() < 10; k++) begin
         @(negedge clock);
         if (bus.ls_rvalid === 1'b1) got_q.push_back(1'b0);
         if (bus.if_rvalid === 1'b1) got_q.push_back(1'b1);
      end
      bus.ls_req = 1'b0; bus.if_req = 1'b0;
      total++; if (got_q.size() != 10) begin bad++; $display("FAIL arb_count got=%0d exp=10", got_q.size()); end
      for (int g = 0; g < exp_q.size() && g < got_q.size(); g++) begin
         total++; if (got_q[g] !== exp_q[g]) begin bad++; $display("FAIL arb_grant[%0d] got=%s exp=%s", g, got_q[g] ? "IF" : "LS", exp_q[g] ? "IF" : "LS"); end
      end
   endtask

   task automatic test_random();
      logic [31:0] addr, wd, rd, e_wd, e_rd; logic [2:0] f3; logic we, er, e_err, is_ls;
      logic [MEM_AW-1:0] e_ma; logic [3:0] e_be; int lat, reqs, ml;
      for (int n = 0; n < 60; n++) begin
         is_ls    = ($urandom_range(0, 3) != 0);
         f3       = 3'($urandom_range(0, 7));
         we       = 1'($urandom_range(0, 1));
         wd       = $urandom;
         mem_word = $urandom;
         ml       = $urandom_range(0, 3);
         mem_lat  = ml;
         case ($urandom_range(0, 4))
            0:       addr = BASE + $urandom_range(0, 1023);
            1:       addr = BASE + 32'h03FF_FF00 + $urandom_range(0, 255);
            2:       addr = BASE - $urandom_range(1, 16);
            3:       addr = BASE + 32'h0400_0000 + $urandom_range(0, 16);
            default: addr = $urandom;
         endcase
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         ref_access(is_ls, we, f3, addr, wd, mem_word, e_err, e_ma, e_be, e_wd, e_rd);
         if (is_ls) ls_txn(we, f3, addr, wd, rd, er, lat, reqs);
         else       if_txn(addr, rd, er, lat, reqs);
         total++; if (er !== e_err) begin bad++; $display("FAIL rnd_err n=%0d addr=%h f3=%b got=%b exp=%b", n, addr, f3, er, e_err); end
         total++; if (rd !== e_rd) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%h f3=%b got=%h exp=%h", n, addr, f3, rd, e_rd); end
         total++; if (lat != (e_err ? 1 : ml + 2)) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, lat, e_err ? 1 : ml + 2); end
         if (e_err) begin
            total++; if (reqs != 0) begin bad++; $display("FAIL rnd_fault_memreq n=%0d got=%0d exp=0", n, reqs); end
         end else begin
            total++; if (reqs != ml + 1) begin bad++; $display("FAIL rnd_req_cycles n=%0d got=%0d exp=%0d", n, reqs, ml + 1); end
            total++; if (cap_addr !== e_ma) begin bad++; $display("FAIL rnd_mem_addr n=%0d got=%h exp=%h", n, cap_addr, e_ma); end
            total++; if (cap_be !== e_be) begin bad++; $display("FAIL rnd_be n=%0d got=%b exp=%b", n, cap_be, e_be); end
            total++; if (cap_we !== (is_ls && we)) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, cap_we, is_ls && we); end
            if (is_ls && we) begin
               total++; if (cap_wdata !== e_wd) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, cap_wdata, e_wd); end
            end
         end
      end
      mem_lat = 0;
   endtask

   task automatic test_reset_mid();
      int rv0;
      @(negedge clock);
      mem_lat = -1;
      bus.ls_we = 1'b0; bus.ls_func3 = 3'b010; bus.ls_addr = BASE + 32'h80; bus.ls_wdata = 32'h0;
      bus.ls_req = 1'b1;
      repeat (4) @(negedge clock);
      total++; if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midreset_pre got req=%b busy=%b exp 1/1", bus.mem_req, busy); end
      rv0 = rv_cnt;
      #2 reset = 1'b0;
      #1;
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL midreset_memreq got=%b exp=0", bus.mem_req); end
      total++; if (busy !== 1'b0 || bus.ls_rvalid !== 1'b0) begin bad++; $display("FAIL midreset_idle got busy=%b rvalid=%b exp 0/0", busy, bus.ls_rvalid); end
      bus.ls_req = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      total++; if (rv_cnt != rv0) begin bad++; $display("FAIL midreset_rvalid got=%0d pulses exp=0", rv_cnt - rv0); end
      total++; if (dbg_state !== 2'd0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL midreset_state got=%0d/%b exp=0/0", dbg_state, bus.mem_req); end
      mem_lat = 0;
   endtask

   task automatic test_no_overlap();
      total++; if (overlap_cnt != 0) begin bad++; $display("FAIL rvalid_overlap got=%0d exp=0", overlap_cnt); end
   endtask

   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_func3 = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
      test_reset();
      test_fetch();
      test_extension();
      test_faults();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_no_overlap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
